// File: rtl/acq_pkg.sv
// Shared acquisition-path definitions: result width, entry packing, FWFT output state.
package acq_pkg;

    localparam int unsigned ADC_RESULT_WIDTH = 24;

    // Entry layout is {diap, ch2, ch1}; the formatter unpacks with the same constants.
    localparam int unsigned ENTRY_W  = 2 * ADC_RESULT_WIDTH + 1;
    localparam int unsigned DIAP_BIT = ENTRY_W - 1;

    // Output register state: EMPTY holds nothing, VALID presents the head entry.
    typedef enum logic {
        OutEmpty = 1'b0,
        OutValid = 1'b1
    } out_state_e;

    // Entry width for an arbitrary channel word width.
    function automatic int unsigned entry_width(input int unsigned data_w);
        return 2 * data_w + 1;
    endfunction

endpackage

// File: rtl/fifo_ram_2p.sv
// Two-port storage array: synchronous write, asynchronous read, no reset.
module fifo_ram_2p #(
    parameter int unsigned AddrW = 3,
    parameter int unsigned Width = 49
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AddrW-1:0] waddr_i,
    input  logic [Width-1:0] wdata_i,
    input  logic [AddrW-1:0] raddr_i,
    output logic [Width-1:0] rdata_o
);

    localparam int unsigned Depth = 2 ** AddrW;

    logic [Width-1:0] mem_q [Depth];

    // Write port: one entry per enabled clock edge.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/adc_result_fifo.sv
// Buffers completed ADC result pairs plus mode tag in a first-word-fall-through FIFO.
// The head entry lives in output registers; the RAM only holds entries behind it.
module adc_result_fifo
    import acq_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = ADC_RESULT_WIDTH,
    parameter int unsigned DEPTH_LOG2 = 3,
    parameter int unsigned DROP_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  complete,
    input  logic                  read_diapason,
    input  logic [DATA_WIDTH-1:0] data_in_1,
    input  logic [DATA_WIDTH-1:0] data_in_2,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data_1,
    output logic [DATA_WIDTH-1:0] out_data_2,
    output logic                  out_diap,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    output logic [DROP_WIDTH-1:0] drop_count,
    input  logic                  clear_ovf
);

    localparam int unsigned EntryW  = entry_width(DATA_WIDTH);
    localparam int unsigned DiapBit = EntryW - 1;
    localparam logic [DEPTH_LOG2:0] LevelFull = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DROP_WIDTH-1:0] DropOne = {{(DROP_WIDTH-1){1'b0}}, 1'b1};

    logic                  c1_q, c2_q;
    logic                  cap, pop, full, accept, drop, load, mem_empty;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    out_state_e            state_q, state_d;
    logic [EntryW-1:0]     head_q, head_d, cap_entry, ram_rdata;
    logic                  ram_we;
    logic                  overflow_q, overflow_d;
    logic [DROP_WIDTH-1:0] drop_q, drop_d;

    // Upstream data settles one cycle after complete rises, so capture on the delayed edge.
    assign cap       = c1_q & ~c2_q;
    assign cap_entry = {read_diapason, data_in_2, data_in_1};

    assign pop       = (state_q == OutValid) & out_ready;
    assign full      = (level_q == LevelFull);
    assign accept    = cap & (~full | pop);
    assign drop      = cap & full & ~pop;
    assign mem_empty = (wr_ptr_q == rd_ptr_q);
    // Output regs need refilling when empty or when the head leaves this edge.
    assign load      = (state_q == OutEmpty) | pop;

    fifo_ram_2p #(
        .AddrW (DEPTH_LOG2),
        .Width (EntryW)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (ram_we),
        .waddr_i (wr_ptr_q),
        .wdata_i (cap_entry),
        .raddr_i (rd_ptr_q),
        .rdata_o (ram_rdata)
    );

    // Complete edge-detect pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c1_q <= 1'b0;
            c2_q <= 1'b0;
        end else begin
            c1_q <= complete;
            c2_q <= c1_q;
        end
    end

    // FWFT output state, head register and pointer next-state.
    always_comb begin
        state_d  = state_q;
        head_d   = head_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        ram_we   = 1'b0;
        if (load) begin
            if (!mem_empty) begin
                head_d   = ram_rdata;
                rd_ptr_d = rd_ptr_q + 1'b1;
                state_d  = OutValid;
                if (accept) begin
                    ram_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                end
            end else if (accept) begin
                // Nothing queued behind the head: bypass straight into the output regs.
                head_d  = cap_entry;
                state_d = OutValid;
            end else begin
                state_d = OutEmpty;
            end
        end else if (accept) begin
            ram_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
    end

    // Occupancy counts the presented head as well as queued entries.
    always_comb begin
        level_d = level_q;
        case ({accept, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // Drop bookkeeping; a drop in the same cycle as clear_ovf wins and counts as the first.
    always_comb begin
        overflow_d = overflow_q;
        drop_d     = drop_q;
        if (drop) begin
            overflow_d = 1'b1;
            if (clear_ovf) begin
                drop_d = DropOne;
            end else if (!(&drop_q)) begin
                drop_d = drop_q + 1'b1;
            end
        end else if (clear_ovf) begin
            overflow_d = 1'b0;
            drop_d     = '0;
        end
    end

    // State registers for the FIFO body.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= OutEmpty;
            head_q     <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    assign out_valid  = (state_q == OutValid);
    assign out_data_1 = head_q[DATA_WIDTH-1:0];
    assign out_data_2 = head_q[2*DATA_WIDTH-1:DATA_WIDTH];
    assign out_diap   = head_q[DiapBit];
    assign level      = level_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_q;

endmodule
